// File: rtl/vga_frame_reader_if.sv
// Bundle between the VGA frame reader, the data-memory VGA port and the display side.
// The master is the reader. The slave is the memory/display environment.
interface vga_frame_reader_if;
    logic        pix_en;
    logic        gray_mode;
    logic [31:0] rd_data;
    logic [15:0] rd_addr;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [9:0]  column;
    logic [9:0]  row;
    logic        frame_start;

    modport master (
        input  pix_en, gray_mode, rd_data,
        output rd_addr, hsync, vsync, blank_n, red, green, blue, column, row, frame_start
    );

    modport slave (
        output pix_en, gray_mode, rd_data,
        input  rd_addr, hsync, vsync, blank_n, red, green, blue, column, row, frame_start
    );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA timing generator and image-window reader: beam position -> column-major read address,
// returned byte -> RGB, with syncs delayed two pixel ticks to line up with the pixel data.
module vga_frame_reader #(
    parameter int unsigned H_VIS = 640,
    parameter int unsigned H_FP  = 16,
    parameter int unsigned H_SYN = 96,
    parameter int unsigned H_BP  = 48,
    parameter int unsigned V_VIS = 480,
    parameter int unsigned V_FP  = 10,
    parameter int unsigned V_SYN = 2,
    parameter int unsigned V_BP  = 33,
    parameter int unsigned IMG_W = 200,
    parameter int unsigned IMG_H = 200
) (
    input logic               clk,
    input logic               reset,
    vga_frame_reader_if.master bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYN + H_BP;
    localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYN + V_BP;
    localparam int unsigned HS_BEG = H_VIS + H_FP;
    localparam int unsigned HS_END = HS_BEG + H_SYN;
    localparam int unsigned VS_BEG = V_VIS + V_FP;
    localparam int unsigned VS_END = VS_BEG + V_SYN;
    localparam logic [ADDR_W-1:0] ADDR_NONE = '1;

    logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              in_win0_q, in_win0_d, vis0_q, vis0_d, hs0_q, hs0_d, vs0_q, vs0_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
    logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic              frame_start_q, frame_start_d, started_q, started_d;

    logic              h_wrap, v_wrap, in_win, vis, hs_raw, vs_raw;
    logic [7:0]        px, r_exp, g_exp, b_exp;

    // Next-state logic: everything advances only on a pixel tick.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        rd_addr_d     = rd_addr_q;
        in_win0_d     = in_win0_q;
        vis0_d        = vis0_q;
        hs0_d         = hs0_q;
        vs0_d         = vs0_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_n_d     = blank_n_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        frame_start_d = 1'b0;
        started_d     = 1'b1;

        h_wrap = (h_q == CNT_W'(H_TOT - 1));
        v_wrap = (v_q == CNT_W'(V_TOT - 1));
        in_win = (h_q < CNT_W'(IMG_W)) && (v_q < CNT_W'(IMG_H));
        vis    = (h_q < CNT_W'(H_VIS)) && (v_q < CNT_W'(V_VIS));
        hs_raw = !((h_q >= CNT_W'(HS_BEG)) && (h_q < CNT_W'(HS_END)));
        vs_raw = !((v_q >= CNT_W'(VS_BEG)) && (v_q < CNT_W'(VS_END)));

        // RGB332 expands by bit replication so full-scale codes reach 8'hFF.
        px = bus.rd_data[7:0];
        if (bus.gray_mode) begin
            r_exp = px;
            g_exp = px;
            b_exp = px;
        end else begin
            r_exp = {px[7:5], px[7:5], px[7:6]};
            g_exp = {px[4:2], px[4:2], px[4:3]};
            b_exp = {px[1:0], px[1:0], px[1:0], px[1:0]};
        end

        // Syncs go inactive on the first edge out of reset even before the first tick.
        if (!started_q) begin
            hsync_d = 1'b1;
            vsync_d = 1'b1;
        end

        if (bus.pix_en) begin
            h_d = h_wrap ? '0 : h_q + CNT_W'(1);
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + CNT_W'(1);
            end
            frame_start_d = h_wrap && v_wrap;

            rd_addr_d = in_win ? (ADDR_W'(h_q) * ADDR_W'(IMG_H) + ADDR_W'(v_q)) : ADDR_NONE;
            in_win0_d = in_win;
            vis0_d    = vis;
            hs0_d     = hs_raw;
            vs0_d     = vs_raw;

            hsync_d   = hs0_q;
            vsync_d   = vs0_q;
            blank_n_d = vis0_q;
            red_d     = (vis0_q && in_win0_q) ? r_exp : 8'h00;
            green_d   = (vis0_q && in_win0_q) ? g_exp : 8'h00;
            blue_d    = (vis0_q && in_win0_q) ? b_exp : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            rd_addr_q     <= ADDR_NONE;
            in_win0_q     <= 1'b0;
            vis0_q        <= 1'b0;
            hs0_q         <= 1'b1;
            vs0_q         <= 1'b1;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            blank_n_q     <= 1'b0;
            red_q         <= 8'h00;
            green_q       <= 8'h00;
            blue_q        <= 8'h00;
            frame_start_q <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            rd_addr_q     <= rd_addr_d;
            in_win0_q     <= in_win0_d;
            vis0_q        <= vis0_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            frame_start_q <= frame_start_d;
            started_q     <= started_d;
        end
    end

    assign bus.rd_addr     = rd_addr_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.blank_n     = blank_n_q;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.column      = h_q;
    assign bus.row         = v_q;
    assign bus.frame_start = frame_start_q;
endmodule
